// File: rtl/act_buf_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : act_buf_stream_reader_pkg
// Purpose  : Shared constants and FSM encoding for the activation-buffer
//            stream reader and its word unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package act_buf_stream_reader_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_DWIDTH    = 64;
    localparam int DEF_AWIDTH    = 7;
    localparam int DEF_BYTES_PW  = 8;
    localparam int DEF_NUM_WORDS = 128;

    // Reader control state: waiting for a sync token, or draining a frame.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage : act_buf_stream_reader_pkg
`default_nettype wire

// File: rtl/act_buf_stream_reader_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : act_word_unpacker
// Purpose  : Holds the word currently being streamed, shifts it out one byte
//            per AXI-stream handshake (byte 0 = bits [7:0] first) and raises
//            TLAST on the final byte of the frame's last word.
// Revision : 1.0 - initial release
// ============================================================================
module act_word_unpacker
    import act_buf_stream_reader_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int BYTES_PW = DEF_BYTES_PW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DWIDTH-1:0] i_word,
    input  logic              i_last_word,
    input  logic              i_tready,
    output logic              o_ready,
    output logic              o_done,
    output logic [BYTE_W-1:0] o_tdata,
    output logic              o_tvalid,
    output logic              o_tlast
);

    localparam int              c_IW       = (BYTES_PW > 1) ? $clog2(BYTES_PW) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(BYTES_PW - 1);

    logic [DWIDTH-1:0] r_shift;
    logic [c_IW-1:0]   r_idx;
    logic              r_valid;
    logic              r_last_word;

    logic w_xfer;
    logic w_word_end;

    assign w_xfer     = r_valid & i_tready;
    assign w_word_end = w_xfer & (r_idx == c_LAST_IDX);

    // A new word may enter when empty, or in the very cycle the last byte
    // leaves, which keeps the stream free of bubbles between words.
    assign o_ready  = ~r_valid | w_word_end;
    assign o_done   = w_word_end & r_last_word;
    assign o_tdata  = r_shift[BYTE_W-1:0];
    assign o_tvalid = r_valid;
    assign o_tlast  = r_valid & r_last_word & (r_idx == c_LAST_IDX);

    // Current-word shift register and byte index; holds still while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_last_word <= 1'b0;
        end else if (i_load) begin
            r_shift     <= i_word;
            r_idx       <= '0;
            r_valid     <= 1'b1;
            r_last_word <= i_last_word;
        end else if (w_word_end) begin
            r_valid     <= 1'b0;
            r_last_word <= 1'b0;
        end else if (w_xfer) begin
            r_shift     <= r_shift >> BYTE_W;
            r_idx       <= r_idx + c_IW'(1);
        end
    end

endmodule : act_word_unpacker
`default_nettype wire

// File: rtl/act_buf_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : act_buf_stream_reader
// Purpose  : Accepts the buffer-full sync token, reads the activation BRAM
//            word by word and streams it out as bytes over AXI-stream with
//            TLAST on the final byte of the frame.
// Revision : 1.0 - initial release
// ============================================================================
module act_buf_stream_reader
    import act_buf_stream_reader_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int BYTES_PW  = DEF_BYTES_PW,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              SyncSig_V,
    input  logic              SyncSig_V_ap_vld,
    output logic              SyncSig_V_ap_ack,
    output logic [AWIDTH-1:0] ActBuf_Data_address0,
    output logic              ActBuf_Data_ce0,
    input  logic [DWIDTH-1:0] ActBuf_Data_q0,
    output logic [7:0]        ActOut_V_TDATA,
    output logic              ActOut_V_TVALID,
    output logic              ActOut_V_TLAST,
    input  logic              ActOut_V_TREADY
);

    // Word counter is one bit wider than the address so it can reach
    // NUM_WORDS without aliasing back onto word 0.
    localparam logic [AWIDTH:0] c_LAST_WORD = (AWIDTH + 1)'(NUM_WORDS - 1);

    state_t            r_state;
    logic [AWIDTH:0]   r_wcnt;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [DWIDTH-1:0] r_nxt;
    logic              r_nxt_vld;
    logic              r_nxt_last;

    logic              w_ack;
    logic              w_start;
    logic              w_issue;
    logic              w_load;
    logic [DWIDTH-1:0] w_load_word;
    logic              w_load_last;
    logic              w_un_ready;
    logic              w_un_done;

    // Token handshake is only offered in IDLE; a valid-frame token also
    // launches the read of word 0 in the same cycle.
    assign w_ack   = (r_state == ST_IDLE) & SyncSig_V_ap_vld & ~ap_rst;
    assign w_start = w_ack & SyncSig_V;

    // One read at a time, only into an empty next-word slot, never past the
    // last word of the frame.
    assign w_issue = (r_state == ST_STREAM) & ~ap_rst & ~r_nxt_vld & ~r_inflight
                   & (r_wcnt <= c_LAST_WORD);

    assign SyncSig_V_ap_ack     = w_ack;
    assign ActBuf_Data_ce0      = w_start | w_issue;
    assign ActBuf_Data_address0 = w_issue ? r_wcnt[AWIDTH-1:0] : '0;

    // The unpacker takes the buffered word if there is one, otherwise it
    // takes q0 straight from the BRAM so the first byte appears at T+2.
    assign w_load      = (r_state == ST_STREAM) & w_un_ready & (r_nxt_vld | r_inflight);
    assign w_load_word = r_nxt_vld ? r_nxt      : ActBuf_Data_q0;
    assign w_load_last = r_nxt_vld ? r_nxt_last : r_inflight_last;

    act_word_unpacker #(
        .DWIDTH   (DWIDTH),
        .BYTES_PW (BYTES_PW)
    ) u_unpacker (
        .clk         (ap_clk),
        .rst         (ap_rst),
        .i_load      (w_load),
        .i_word      (w_load_word),
        .i_last_word (w_load_last),
        .i_tready    (ActOut_V_TREADY),
        .o_ready     (w_un_ready),
        .o_done      (w_un_done),
        .o_tdata     (ActOut_V_TDATA),
        .o_tvalid    (ActOut_V_TVALID),
        .o_tlast     (ActOut_V_TLAST)
    );

    // Frame FSM, read tracking and next-word holding register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state         <= ST_IDLE;
            r_wcnt          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_nxt           <= '0;
            r_nxt_vld       <= 1'b0;
            r_nxt_last      <= 1'b0;
        end else begin
            r_inflight <= w_start | w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state         <= ST_STREAM;
                        r_wcnt          <= (AWIDTH + 1)'(1);
                        r_inflight_last <= (c_LAST_WORD == '0);
                        r_nxt_vld       <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (w_issue) begin
                        r_wcnt          <= r_wcnt + (AWIDTH + 1)'(1);
                        r_inflight_last <= (r_wcnt == c_LAST_WORD);
                    end
                    // Returning data lands in the slot unless the unpacker
                    // consumed it directly this cycle.
                    if (r_inflight && !(w_load && !r_nxt_vld)) begin
                        r_nxt      <= ActBuf_Data_q0;
                        r_nxt_vld  <= 1'b1;
                        r_nxt_last <= r_inflight_last;
                    end else if (w_load && r_nxt_vld) begin
                        r_nxt_vld  <= 1'b0;
                    end
                    if (w_un_done) begin
                        r_state <= ST_IDLE;
                        r_wcnt  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : act_buf_stream_reader
`default_nettype wire
